gray_sched: RTL and testbench

Round-robin scheduler that shares one 3-bit Gray-code step counter among `NREQ` requesters. Each requester asks for a burst of N counter steps. The scheduler grants one requester at a time, drives the counter's enable for exactly N cycles, then pulses that requester's done flag. It sits between client logic and the Gray counter core and is the only block allowed to advance the counter.

---
 rtl/gray_pkg.sv | 36 +++
 rtl/gray_step_core.sv | 42 ++++
 rtl/gray_sched.sv | 116 +++++++++++
 tb/tb_gray_sched.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// Shared definitions for the Gray step scheduler: FSM encoding, Gray sequence and stepping.
package gray_pkg;

  localparam int unsigned GRAY_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [GRAY_W-1:0] GRAY_0 = 3'b000;
  localparam logic [GRAY_W-1:0] GRAY_1 = 3'b001;
  localparam logic [GRAY_W-1:0] GRAY_2 = 3'b011;
  localparam logic [GRAY_W-1:0] GRAY_3 = 3'b010;
  localparam logic [GRAY_W-1:0] GRAY_4 = 3'b110;
  localparam logic [GRAY_W-1:0] GRAY_5 = 3'b111;
  localparam logic [GRAY_W-1:0] GRAY_6 = 3'b101;
  localparam logic [GRAY_W-1:0] GRAY_7 = 3'b100;

  function automatic logic [GRAY_W-1:0] gray_next(input logic [GRAY_W-1:0] g);
    logic [GRAY_W-1:0] n;
    case (g)
      GRAY_0:  n = GRAY_1;
      GRAY_1:  n = GRAY_2;
      GRAY_2:  n = GRAY_3;
      GRAY_3:  n = GRAY_4;
      GRAY_4:  n = GRAY_5;
      GRAY_5:  n = GRAY_6;
      GRAY_6:  n = GRAY_7;
      default: n = GRAY_0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/gray_step_core.sv
// 3-bit Gray step counter with sticky wrap flag.
// Optional saturating wrap counter under GRAY_SCHED_WRAP_CNT_EN.
module gray_step_core
  import gray_pkg::*;
(
  input  logic              Clk,
  input  logic              Reset,
  input  logic              En,
  output logic [GRAY_W-1:0] Output,
  output logic              Overflow
`ifdef GRAY_SCHED_WRAP_CNT_EN
  ,
  output logic [7:0]        WrapCnt
`endif
);

  logic wrap_c;

  // A wrap is the enabled step out of the last code of the sequence.
  assign wrap_c = En && (Output == GRAY_7);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      Output   <= GRAY_0;
      Overflow <= 1'b0;
    end else if (En) begin
      Output <= gray_next(Output);
      if (wrap_c) Overflow <= 1'b1;
    end
  end

`ifdef GRAY_SCHED_WRAP_CNT_EN
  always_ff @(posedge Clk) begin
    if (Reset) begin
      WrapCnt <= 8'd0;
    end else if (wrap_c && (WrapCnt != 8'hFF)) begin
      WrapCnt <= WrapCnt + 8'd1;
    end
  end
`endif

endmodule

// File: rtl/gray_sched.sv
// Round-robin scheduler granting bursts of Gray counter steps to NREQ requesters.
// Optional WrapCnt output under GRAY_SCHED_WRAP_CNT_EN.
module gray_sched
  import gray_pkg::*;
#(
  parameter int unsigned NREQ   = 2,
  parameter int unsigned STEP_W = 4
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic [NREQ-1:0]        Req,
  input  logic [NREQ*STEP_W-1:0] Steps,
  output logic [NREQ-1:0]        Grant,
  output logic [NREQ-1:0]        Done,
  output logic                   Busy,
  output logic [GRAY_W-1:0]      Output,
  output logic                   Overflow
`ifdef GRAY_SCHED_WRAP_CNT_EN
  ,
  output logic [7:0]             WrapCnt
`endif
);

  localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    owner_q, owner_d;
  logic [IDX_W-1:0]    last_q, last_d;
  logic [STEP_W-1:0]   remain_q, remain_d;
  logic [IDX_W-1:0]    cand;
  logic                found;
  logic [NREQ-1:0]     grant_d, done_d;
  logic                busy_d;
  logic                en_c;

  // State, burst bookkeeping and registered outputs.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= ST_IDLE;
      owner_q  <= '0;
      last_q   <= IDX_W'(NREQ - 1);
      remain_q <= '0;
      Grant    <= '0;
      Done     <= '0;
      Busy     <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      remain_q <= remain_d;
      Grant    <= grant_d;
      Done     <= done_d;
      Busy     <= busy_d;
    end
  end

  // Next state: round-robin pick in IDLE, step countdown in RUN.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    remain_d = remain_q;
    cand     = '0;
    found    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|Req) begin
          for (int unsigned k = 1; k <= NREQ; k++) begin
            cand = IDX_W'((32'(last_q) + k) % NREQ);
            if (!found && Req[cand]) begin
              found   = 1'b1;
              owner_d = cand;
            end
          end
          remain_d = Steps[owner_d*STEP_W +: STEP_W];
          state_d  = (remain_d == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        remain_d = remain_q - STEP_W'(1);
        if (remain_q <= STEP_W'(1)) state_d = ST_DONE;
      end
      ST_DONE: begin
        last_d  = owner_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they land registered with it.
  always_comb begin
    grant_d = '0;
    done_d  = '0;
    busy_d  = 1'b0;
    en_c    = (state_q == ST_RUN);
    if (state_d != ST_IDLE) begin
      grant_d = NREQ'(1) << owner_d;
      busy_d  = 1'b1;
    end
    if (state_d == ST_DONE) done_d = NREQ'(1) << owner_d;
  end

  gray_step_core u_core (
    .Clk      (Clk),
    .Reset    (Reset),
    .En       (en_c),
    .Output   (Output),
    .Overflow (Overflow)
`ifdef GRAY_SCHED_WRAP_CNT_EN
    ,
    .WrapCnt  (WrapCnt)
`endif
  );

endmodule

// File: tb/tb_gray_sched.sv
// Scoreboard bench for gray_sched (NREQ=2, STEP_W=4); checks WrapCnt when GRAY_SCHED_WRAP_CNT_EN is set.
module tb_gray_sched;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [1:0] Req;
  logic [7:0] Steps;
  logic [1:0] Grant;
  logic [1:0] Done;
  logic       Busy;
  logic [2:0] Output;
  logic       Overflow;
`ifdef GRAY_SCHED_WRAP_CNT_EN
  logic [7:0] WrapCnt;
`endif

  gray_sched #(.NREQ(2), .STEP_W(4)) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .Req      (Req),
    .Steps    (Steps),
    .Grant    (Grant),
    .Done     (Done),
    .Busy     (Busy),
    .Output   (Output),
    .Overflow (Overflow)
`ifdef GRAY_SCHED_WRAP_CNT_EN
    ,
    .WrapCnt  (WrapCnt)
`endif
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [1:0] done;
    logic [2:0] out;
    logic       ovf;
  } exp_t;

  exp_t       sb[$];
  logic [2:0] seq [8] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};
  int         tests = 0;
  int         fails = 0;
  int         m_pos, m_last, m_wraps;
  logic       m_ovf;

  function automatic int pick(input logic [1:0] req, input int last);
    for (int k = 1; k <= 2; k++) begin
      int idx;
      idx = (last + k) % 2;
      if (req[idx]) return idx;
    end
    return -1;
  endfunction

  // One burst: push the expected completion, then watch grant timing and pop on Done.
  task automatic burst(input logic [1:0] req, input logic [7:0] steps, input bit drop,
                       input string name);
    int owner, n, gcyc, first;
    bit got;
    exp_t e;
    logic [1:0] oh;
    owner = pick(req, m_last);
    n     = int'(steps[owner*4 +: 4]);
    oh    = 2'(1 << owner);
    m_wraps = m_wraps + (m_pos + n) / 8;
    if (m_wraps > 255) m_wraps = 255;
    if (m_pos + n >= 8) m_ovf = 1'b1;
    m_pos = (m_pos + n) % 8;
    sb.push_back('{done: oh, out: seq[m_pos], ovf: m_ovf});
    Req = req;
    Steps = steps;
    gcyc = 0; first = 0; got = 0;
    for (int c = 1; c <= 40 && !got; c++) begin
      @(negedge Clk);
      if (Grant !== 2'b00) begin
        gcyc++;
        if (gcyc == 1) first = c;
        tests++;
        if (Grant !== oh || Busy !== 1'b1) begin
          fails++;
          $display("FAIL %s grant: got grant=%b busy=%b exp grant=%b busy=1", name, Grant, Busy, oh);
        end
        if (drop && gcyc == 1) Req = 2'b00;
      end
      if (Done !== 2'b00) begin
        got = 1;
        e = sb.pop_front();
        tests++;
        if (Done !== e.done) begin
          fails++; $display("FAIL %s done: got %b exp %b", name, Done, e.done);
        end
        tests++;
        if (Output !== e.out) begin
          fails++; $display("FAIL %s output: got %b exp %b", name, Output, e.out);
        end
        tests++;
        if (Overflow !== e.ovf) begin
          fails++; $display("FAIL %s overflow: got %b exp %b", name, Overflow, e.ovf);
        end
      end
    end
    tests++;
    if (!got) begin
      fails++; $display("FAIL %s timeout: no Done within 40 cycles, exp Done=%b", name, oh);
      void'(sb.pop_front());
    end
    tests++;
    if (first != 1 || gcyc != n + 1) begin
      fails++;
      $display("FAIL %s timing: got latency=%0d grant_cycles=%0d exp latency=1 grant_cycles=%0d",
               name, first, gcyc, n + 1);
    end
    @(negedge Clk);
    tests++;
    if (Grant !== 2'b00 || Busy !== 1'b0 || Done !== 2'b00) begin
      fails++;
      $display("FAIL %s idle: got grant=%b busy=%b done=%b exp 00/0/00", name, Grant, Busy, Done);
    end
    m_last = owner;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    Req = 2'b00;
    Steps = 8'h00;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    m_pos = 0; m_last = 1; m_ovf = 1'b0; m_wraps = 0;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    Req = 2'b11;
    Steps = 8'h33;
    repeat (2) @(negedge Clk);
    tests++;
    if (Grant !== 2'b00 || Done !== 2'b00 || Busy !== 1'b0) begin
      fails++; $display("FAIL reset ctrl: got grant=%b done=%b busy=%b exp 00/00/0", Grant, Done, Busy);
    end
    tests++;
    if (Output !== 3'b000 || Overflow !== 1'b0) begin
      fails++; $display("FAIL reset count: got out=%b ovf=%b exp 000/0", Output, Overflow);
    end
    do_reset();
  endtask

  task automatic test_single();
    burst(2'b01, 8'h03, 1'b0, "single");
    tests++;
    if (Output !== 3'b010) begin
      fails++; $display("FAIL single hold: got %b exp 010", Output);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    burst(2'b01, 8'h09, 1'b0, "wrap");
    tests++;
    if (Overflow !== 1'b1 || Output !== 3'b001) begin
      fails++; $display("FAIL wrap sticky: got ovf=%b out=%b exp 1/001", Overflow, Output);
    end
`ifdef GRAY_SCHED_WRAP_CNT_EN
    tests++;
    if (WrapCnt !== 8'(m_wraps)) begin
      fails++; $display("FAIL wrap count: got %0d exp %0d", WrapCnt, m_wraps);
    end
`endif
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < 4; i++) burst(2'b11, 8'h22, 1'b0, "round_robin");
  endtask

  task automatic test_zero_step();
    burst(2'b10, 8'h05, 1'b0, "zero_step");
  endtask

  task automatic test_reset_mid_burst();
    bit seen;
    do_reset();
    Req = 2'b01;
    Steps = 8'h05;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge Clk);
      if (Grant !== 2'b00) seen = 1;
    end
    @(negedge Clk);
    tests++;
    if (!seen || Output !== 3'b001) begin
      fails++; $display("FAIL mid_burst run2: got seen=%0d out=%b exp 1/001", seen, Output);
    end
    Reset = 1'b1;
    Req = 2'b00;
    @(negedge Clk);
    tests++;
    if (Output !== 3'b000 || Grant !== 2'b00 || Busy !== 1'b0 || Done !== 2'b00) begin
      fails++;
      $display("FAIL mid_burst reset: got out=%b grant=%b busy=%b done=%b exp 000/00/0/00",
               Output, Grant, Busy, Done);
    end
    Reset = 1'b0;
    m_pos = 0; m_last = 1; m_ovf = 1'b0; m_wraps = 0;
    burst(2'b11, 8'h11, 1'b0, "after_reset");
  endtask

  task automatic test_req_drop();
    burst(2'b10, 8'h40, 1'b1, "req_drop");
  endtask

  task automatic test_back_to_back();
    logic [1:0] r;
    logic [7:0] s;
    for (int i = 0; i < 6; i++) begin
      r = 2'($urandom_range(1, 3));
      s = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      burst(r, s, 1'b0, "back_to_back");
    end
  endtask

  initial begin
    Reset = 1'b1;
    Req = 2'b00;
    Steps = 8'h00;
    m_pos = 0; m_last = 1; m_ovf = 1'b0; m_wraps = 0;
    test_reset();
    test_single();
    test_wrap();
    test_round_robin();
    test_zero_step();
    test_reset_mid_burst();
    test_req_drop();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
